// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen_pkg
// Description : Shared types and constants for the tick_gen enable-pulse
//               generator (FSM state encoding, mode codes, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package tick_gen_pkg;

  // Two-state controller: waiting for a start, or dividing the clock.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Operating mode as presented on the mode input.
  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // Default widths of the period divider and the burst counter.
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_BURST_W = 8;

endpackage : tick_gen_pkg
`default_nettype wire

// File: rtl/reload_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : reload_down_counter
// Description : Loadable down-counter with a decrement enable and a zero
//               flag. A load takes priority over a decrement, and the count
//               saturates at zero instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module reload_down_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register: reload wins over decrement; zero is a hard floor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule : reload_down_counter
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Programmable enable-pulse generator. Divides clock by a
//               configurable period and emits single-cycle tick pulses,
//               either continuously or as a burst of N pulses, with
//               start/stop control and busy/done status.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  state_t r_state;
  state_t w_state_next;

  // Configuration captured on an accepted start.
  logic [WIDTH-1:0] r_period;
  logic             r_mode;

  // Registered outputs.
  logic r_tick;
  logic r_busy;
  logic r_done;

  // Next-cycle values and counter controls from the decision logic.
  logic               w_tick_next;
  logic               w_done_next;
  logic               w_busy_next;
  logic               w_latch;
  logic               w_div_load;
  logic [WIDTH-1:0]   w_div_value;
  logic               w_div_dec;
  logic               w_rem_load;
  logic               w_rem_dec;

  // Counter status.
  logic [WIDTH-1:0]   w_div_count;
  logic               w_div_zero;
  logic [BURST_W-1:0] w_rem_count;
  logic               w_rem_zero;
  logic               w_rem_last;

  // A requested period of zero behaves as a period of one.
  logic [WIDTH-1:0]   w_period_eff;
  logic               w_accept;

  // The divider only needs its zero flag; the raw count is left unused.
  logic               w_unused_div_count;

  assign w_period_eff       = (cfg_period == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cfg_period;
  assign w_accept           = start && !stop;
  // Terminate on the final pulse; the zero term keeps rem from ever wrapping.
  assign w_rem_last         = (w_rem_count == {{(BURST_W-1){1'b0}}, 1'b1}) || w_rem_zero;
  assign w_unused_div_count = ^w_div_count;

  // Period divider: counts P_eff-1 down to 0, reloading on every tick.
  reload_down_counter #(
    .W (WIDTH)
  ) u_div (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_div_load),
    .i_load_value (w_div_value),
    .i_dec        (w_div_dec),
    .o_count      (w_div_count),
    .o_zero       (w_div_zero)
  );

  // Burst counter: pulses still to emit in burst mode.
  reload_down_counter #(
    .W (BURST_W)
  ) u_rem (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_rem_load),
    .i_load_value (cfg_burst),
    .i_dec        (w_rem_dec),
    .o_count      (w_rem_count),
    .o_zero       (w_rem_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and counter-control decisions; stop always beats start/tick.
  always_comb begin
    w_state_next = r_state;
    w_tick_next  = 1'b0;
    w_done_next  = 1'b0;
    w_latch      = 1'b0;
    w_div_load   = 1'b0;
    w_div_value  = w_period_eff - 1'b1;
    w_div_dec    = 1'b0;
    w_rem_load   = 1'b0;
    w_rem_dec    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_latch    = 1'b1;
          w_div_load = 1'b1;
          w_rem_load = 1'b1;
          // An empty burst completes at once: done without ever running.
          if ((mode == MODE_BURST) && (cfg_burst == '0)) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = RUN;
          end
        end
      end

      RUN: begin
        if (stop) begin
          // Abort: no tick, no done, back to idle on this edge.
          w_state_next = IDLE;
        end else if (w_div_zero) begin
          w_tick_next = 1'b1;
          w_div_load  = 1'b1;
          w_div_value = r_period - 1'b1;
          if (r_mode == MODE_BURST) begin
            if (w_rem_last) begin
              w_done_next  = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_rem_dec = 1'b1;
            end
          end
        end else begin
          w_div_dec = 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_busy_next = (w_state_next == RUN);

  // Configuration capture on an accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period <= '0;
      r_mode   <= MODE_CONT;
    end else if (w_latch) begin
      r_period <= w_period_eff;
      r_mode   <= mode;
    end
  end

  // Output registers, updated together with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tick <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tick <= w_tick_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  assign tick = r_tick;
  assign busy = r_busy;
  assign done = r_done;

endmodule : tick_gen
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_gen
// Description : Directed self-checking bench for tick_gen, including a 2-bit
//               downstream counter driven by tick.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tick_gen;
  import tick_gen_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_burst;
  logic        mode;
  logic        start;
  logic        stop;
  logic        tick;
  logic        busy;
  logic        done;
  logic [1:0]  ds_out;

  int n_checks = 0;
  int n_fail   = 0;

  tick_gen #(
    .WIDTH   (16),
    .BURST_W (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_period (cfg_period),
    .cfg_burst  (cfg_burst),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream 2-bit counter enabled by tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ds_out <= 2'd0;
    else if (tick) ds_out <= ds_out + 2'd1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Present a start for one edge (edge E0), then scramble config inputs.
  task automatic accept_start(input logic m, input logic [15:0] p, input logic [7:0] n);
    mode       = m;
    cfg_period = p;
    cfg_burst  = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
    cfg_period = 16'd7;
    cfg_burst  = 8'd1;
    mode       = ~m;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    mode = MODE_CONT; cfg_period = 16'd3; cfg_burst = 8'd0;
    #2;
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_mid_run_reset();
    apply_reset();
    accept_start(MODE_CONT, 16'd3, 8'd0);
    step(); step(); step();
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL mrr_tick_before: got %b expected 1", tick); end
    reset = 1'b0;
    #1;
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL mrr_tick: got %b expected 0", tick); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrr_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrr_done: got %b expected 0", done); end
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mrr_after %0d: got tick=%b busy=%b expected 0 0", k, tick, busy); end
    end
  endtask

  task automatic test_continuous();
    logic exp_tick;
    apply_reset();
    accept_start(MODE_CONT, 16'd3, 8'd0);
    n_checks++; if (busy !== 1'b1 || tick !== 1'b0) begin n_fail++; $display("FAIL cont_e0: got busy=%b tick=%b expected 1 0", busy, tick); end
    for (int k = 1; k <= 14; k++) begin
      if (k == 10) stop = 1'b1;
      step();
      stop = 1'b0;
      exp_tick = (k < 10) && (k % 3 == 0);
      n_checks++; if (tick !== exp_tick) begin n_fail++; $display("FAIL cont_tick edge %0d: got %b expected %b", k, tick, exp_tick); end
      n_checks++; if (busy !== (k < 10)) begin n_fail++; $display("FAIL cont_busy edge %0d: got %b expected %b", k, busy, (k < 10)); end
    end
  endtask

  task automatic test_burst();
    logic exp_tick;
    logic exp_done;
    logic exp_busy;
    int   exp_cnt;
    apply_reset();
    accept_start(MODE_BURST, 16'd2, 8'd4);
    n_checks++; if (busy !== 1'b1 || ds_out !== 2'd0) begin n_fail++; $display("FAIL burst_e0: got busy=%b out=%0d expected 1 0", busy, ds_out); end
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_tick = (k % 2 == 0) && (k <= 8);
      exp_done = (k == 8);
      exp_busy = (k < 8);
      exp_cnt  = ((k >= 3) + (k >= 5) + (k >= 7) + (k >= 9)) % 4;
      n_checks++; if (tick !== exp_tick) begin n_fail++; $display("FAIL burst_tick edge %0d: got %b expected %b", k, tick, exp_tick); end
      n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL burst_done edge %0d: got %b expected %b", k, done, exp_done); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL burst_busy edge %0d: got %b expected %b", k, busy, exp_busy); end
      n_checks++; if (ds_out !== exp_cnt[1:0]) begin n_fail++; $display("FAIL burst_out edge %0d: got %0d expected %0d", k, ds_out, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    accept_start(MODE_BURST, 16'd1, 8'd2);
    step();
    n_checks++; if (tick !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_first e1: got tick=%b done=%b expected 1 0", tick, done); end
    step();
    n_checks++; if (tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_first e2: got tick=%b done=%b busy=%b expected 1 1 0", tick, done, busy); end
    accept_start(MODE_BURST, 16'd1, 8'd2);
    n_checks++; if (busy !== 1'b1 || tick !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_second e0: got busy=%b tick=%b done=%b expected 1 0 0", busy, tick, done); end
    step();
    step();
    n_checks++; if (tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_second e2: got tick=%b done=%b busy=%b expected 1 1 0", tick, done, busy); end
  endtask

  task automatic test_p_zero();
    apply_reset();
    accept_start(MODE_CONT, 16'd0, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL pzero_tick edge %0d: got %b expected 1", k, tick); end
    end
    stop_run();
    n_checks++; if (tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL pzero_stop: got tick=%b busy=%b expected 0 0", tick, busy); end
  endtask

  task automatic test_n_zero();
    apply_reset();
    accept_start(MODE_BURST, 16'd5, 8'd0);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL nzero_e0: got done=%b busy=%b tick=%b expected 1 0 0", done, busy, tick); end
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL nzero edge %0d: got done=%b busy=%b tick=%b expected 0 0 0", k, done, busy, tick); end
    end
  endtask

  task automatic test_stop_on_tick();
    apply_reset();
    accept_start(MODE_CONT, 16'd2, 8'd0);
    step();
    n_checks++; if (tick !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL sot_e1: got tick=%b busy=%b expected 0 1", tick, busy); end
    stop_run();
    n_checks++; if (tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sot_e2: got tick=%b busy=%b expected 0 0", tick, busy); end
    for (int k = 3; k <= 6; k++) begin
      step();
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL sot_after edge %0d: got %b expected 0", k, tick); end
    end
  endtask

  task automatic test_start_in_run();
    logic exp_tick;
    apply_reset();
    accept_start(MODE_CONT, 16'd2, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) begin start = 1'b1; cfg_period = 16'd5; mode = MODE_CONT; end
      step();
      start = 1'b0;
      exp_tick = (k % 2 == 0);
      n_checks++; if (tick !== exp_tick) begin n_fail++; $display("FAIL sir_tick edge %0d: got %b expected %b", k, tick, exp_tick); end
    end
    stop_run();
  endtask

  task automatic test_start_stop_idle();
    apply_reset();
    mode = MODE_BURST; cfg_period = 16'd2; cfg_burst = 8'd0;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ssi_burst: got done=%b busy=%b expected 0 0", done, busy); end
    mode = MODE_CONT; cfg_period = 16'd1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL ssi_cont e0: got busy=%b tick=%b expected 0 0", busy, tick); end
    step();
    step();
    n_checks++; if (busy !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL ssi_cont e2: got busy=%b tick=%b expected 0 0", busy, tick); end
  endtask

  initial begin
    test_reset();
    test_mid_run_reset();
    test_continuous();
    test_burst();
    test_back_to_back();
    test_p_zero();
    test_n_zero();
    test_stop_on_tick();
    test_start_in_run();
    test_start_stop_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tick_gen
`default_nettype wire
